fetch_unit: RTL

- Instruction fetch stage; sits directly upstream of the instruction decoder/control stage.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents one 32-bit instruction plus its PC to the decoder over a valid/ready handshake.
- Accepts branch redirects and a halt request from downstream.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_sat_counter.sv | 33 +++
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_S  = 2'd0,
    HOLD_S   = 2'd1,
    DRAIN_S  = 2'd2,
    HALTED_S = 2'd3
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Width-parameterised saturating event counter, used only for the fetch
// statistics outputs (present when FETCH_STATS_EN is defined).
`ifdef FETCH_STATS_EN
module fetch_unit_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack and hands
// instructions to the decoder over valid/ready. Optional macro FETCH_STATS_EN.
//
// state    | meaning
// FETCH_S  | issue and hold the memory request
// HOLD_S   | instruction held for the decoder
// DRAIN_S  | discard the response to a cancelled request
// HALTED_S | fetch stopped until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              hpend_q, hpend_d;
  logic              fetch_evt;
  logic              flush_evt;
  logic [ADDR_W-1:0] rd_tgt;

  assign rd_tgt = redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    hpend_d   = hpend_q;
    fetch_evt = 1'b0;
    flush_evt = 1'b0;

    unique case (state_q)
      FETCH_S: begin
        if (halt_req) begin
          valid_d = 1'b0;
          if (req_q && !imem_ack) begin
            state_d = DRAIN_S;
            hpend_d = 1'b1;
          end else begin
            state_d   = HALTED_S;
            req_d     = 1'b0;
            halted_d  = 1'b1;
            flush_evt = req_q;
          end
        end else if (redirect) begin
          pc_d    = rd_tgt;
          valid_d = 1'b0;
          // An unacked request cannot be withdrawn, so its response is drained.
          if (req_q && !imem_ack) begin
            state_d = DRAIN_S;
          end else begin
            req_d     = 1'b0;
            flush_evt = req_q;
          end
        end else if (req_q) begin
          if (imem_ack) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_INC;
            req_d    = 1'b0;
            state_d  = HOLD_S;
          end
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end

      HOLD_S: begin
        if (halt_req) begin
          state_d   = HALTED_S;
          valid_d   = 1'b0;
          halted_d  = 1'b1;
          flush_evt = 1'b1;
        end else if (redirect) begin
          pc_d      = rd_tgt;
          valid_d   = 1'b0;
          state_d   = FETCH_S;
          flush_evt = 1'b1;
        end else if (valid_q && instr_ready) begin
          valid_d   = 1'b0;
          state_d   = FETCH_S;
          fetch_evt = 1'b1;
        end
      end

      DRAIN_S: begin
        if (halt_req) begin
          hpend_d = 1'b1;
        end else if (redirect) begin
          pc_d = rd_tgt;
        end
        if (imem_ack) begin
          req_d     = 1'b0;
          flush_evt = 1'b1;
          if (halt_req || hpend_q) begin
            state_d  = HALTED_S;
            halted_d = 1'b1;
            hpend_d  = 1'b0;
          end else begin
            state_d = FETCH_S;
          end
        end
      end

      HALTED_S: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH_S;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      hpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      hpend_q  <= hpend_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

`ifdef FETCH_STATS_EN
  fetch_unit_sat_counter #(.W(32)) u_stat_fetched (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (fetch_evt),
    .count_o (stat_fetched)
  );

  fetch_unit_sat_counter #(.W(32)) u_stat_flushed (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_evt),
    .count_o (stat_flushed)
  );
`else
  logic unused_stat_evt;
  assign unused_stat_evt = fetch_evt ^ flush_evt;
`endif

endmodule
